// File: rtl/pipelined_adder_nbit.sv
// Purpose: NUM_STAGES-deep carry-chunked adder with unsigned/signed overflow and a sticky overflow flag.
// Latency: result presented NUM_STAGES-1 edges after the accepting edge; one result per cycle.
// Backpressure: a held output (out_valid && !out_ready) freezes every stage; in_ready is low while frozen.
module pipelined_adder_nbit #(
    parameter int NUM_BITS   = 16,
    parameter int NUM_STAGES = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    input  logic                signed_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow,
    output logic                sticky_ovf
);

    localparam int CHUNK = NUM_BITS / NUM_STAGES;
    localparam int LAST  = NUM_STAGES - 1;
    localparam int MSB   = NUM_BITS - 1;

    if (NUM_BITS < 2 || NUM_STAGES < 1 || (NUM_BITS % NUM_STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder_nbit: NUM_BITS must be >= 2 and divisible by NUM_STAGES");
    end

    // Per-stage registers: delayed operands, partial sum, chunk carry, mode and valid.
    logic [NUM_BITS-1:0]   a_q   [NUM_STAGES];
    logic [NUM_BITS-1:0]   b_q   [NUM_STAGES];
    logic [NUM_BITS-1:0]   sum_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] cy_q;
    logic [NUM_STAGES-1:0] sm_q;
    logic [NUM_STAGES-1:0] vld_q;
    logic                  sticky_q;

    logic [NUM_BITS-1:0]   src_a [NUM_STAGES];
    logic [NUM_BITS-1:0]   src_b [NUM_STAGES];
    logic [NUM_BITS-1:0]   src_s [NUM_STAGES];
    logic [NUM_BITS-1:0]   nxt_s [NUM_STAGES];
    logic [CHUNK:0]        part  [NUM_STAGES];
    logic [NUM_STAGES-1:0] src_c;
    logic [NUM_STAGES-1:0] src_m;
    logic [NUM_STAGES-1:0] src_v;
    logic [NUM_STAGES-1:0] nxt_c;

    always_comb begin
        src_c = '0;
        src_m = '0;
        src_v = '0;
        nxt_c = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            src_a[k] = '0;
            src_b[k] = '0;
            src_s[k] = '0;
            nxt_s[k] = '0;
            part[k]  = '0;
        end
        src_a[0] = a;
        src_b[0] = b;
        src_c[0] = carry_in;
        src_m[0] = signed_mode;
        src_v[0] = in_valid;
        for (int k = 1; k < NUM_STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = sum_q[k-1];
            src_c[k] = cy_q[k-1];
            src_m[k] = sm_q[k-1];
            src_v[k] = vld_q[k-1];
        end
        // Stage k resolves only its own chunk; lower chunks ride along already summed.
        for (int k = 0; k < NUM_STAGES; k++) begin
            part[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                    + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, src_c[k]};
            nxt_s[k] = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            nxt_c[k] = part[k][CHUNK];
        end
    end

    assign out_valid  = vld_q[LAST];
    assign sum        = sum_q[LAST];
    assign in_ready   = !(out_valid && !out_ready);
    assign sticky_ovf = sticky_q;
    assign overflow   = sm_q[LAST]
                      ? ((a_q[LAST][MSB] == b_q[LAST][MSB]) && (sum_q[LAST][MSB] != a_q[LAST][MSB]))
                      : cy_q[LAST];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q    <= '0;
            cy_q     <= '0;
            sm_q     <= '0;
            sticky_q <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (clear) begin
            vld_q    <= '0;
            cy_q     <= '0;
            sm_q     <= '0;
            sticky_q <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            if (in_ready) begin
                vld_q <= src_v;
                cy_q  <= nxt_c;
                sm_q  <= src_m;
                a_q   <= src_a;
                b_q   <= src_b;
                sum_q <= nxt_s;
            end
            if (out_valid && out_ready && overflow) begin
                sticky_q <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (in_valid === 1'b1) begin
            for (int i = 0; i < NUM_BITS; i++) begin
                if ($isunknown(a[i])) $error("pipelined_adder_nbit: a bit %0d is not 0/1", i);
                if ($isunknown(b[i])) $error("pipelined_adder_nbit: b bit %0d is not 0/1", i);
            end
            if ($isunknown(carry_in))    $error("pipelined_adder_nbit: carry_in bit 0 is not 0/1");
            if ($isunknown(signed_mode)) $error("pipelined_adder_nbit: signed_mode bit 0 is not 0/1");
        end
        if ($isunknown(out_ready)) $error("pipelined_adder_nbit: out_ready bit 0 is not 0/1");
    end
`endif

endmodule
